// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: redirect requests in, fetch-unit controls out.
interface fetch_redirect_ctrl_if;
   logic        stall_req;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic        br_req;
   logic [31:0] br_target;
   logic        hang_req;
   logic        im_abs_jump;
   logic [31:0] im_abs_jump_address;
   logic        im_pc_stall;
   logic        im_hang;
   logic        redirect_ack;
   logic        busy;
   modport master (
      output stall_req, exc_req, eret_req, epc, br_req, br_target, hang_req,
      input  im_abs_jump, im_abs_jump_address, im_pc_stall, im_hang, redirect_ack, busy
   );
   modport slave (
      input  stall_req, exc_req, eret_req, epc, br_req, br_target, hang_req,
      output im_abs_jump, im_abs_jump_address, im_pc_stall, im_hang, redirect_ack, busy
   );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates exc/eret/branch redirects into fetch, holds them across stalls, manages hang.
// Define FETCH_REDIRECT_STATS_EN to add saturating per-class redirect counters.
module fetch_redirect_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`ifdef FETCH_REDIRECT_STATS_EN
   , parameter int STAT_WIDTH = 16
`endif
) (
   input  logic clk,
   input  logic reset,
   fetch_redirect_ctrl_if.slave bus
`ifdef FETCH_REDIRECT_STATS_EN
   , output logic [STAT_WIDTH-1:0] stat_exc
   , output logic [STAT_WIDTH-1:0] stat_eret
   , output logic [STAT_WIDTH-1:0] stat_br
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_PEND, S_HANG} state_t;
   // encoding order doubles as priority order for replacement compares
   typedef enum logic [1:0] {C_NONE, C_BR, C_ERET, C_EXC} cls_t;
   state_t      r_state, w_next;
   cls_t        r_pcls, w_pcls_n, w_cls;
   logic [31:0] r_paddr, w_paddr_n, w_addr, w_jaddr;
   logic        w_jump, w_stall, w_hang, w_ack;
   assign w_cls  = bus.exc_req ? C_EXC : bus.eret_req ? C_ERET : bus.br_req ? C_BR : C_NONE;
   assign w_addr = bus.exc_req ? EXC_VECTOR : bus.eret_req ? bus.epc : bus.br_target;
   always_comb begin
      w_next    = r_state;
      w_pcls_n  = r_pcls;
      w_paddr_n = r_paddr;
      w_jump    = 1'b0;
      w_jaddr   = '0;
      w_stall   = 1'b0;
      w_hang    = 1'b0;
      w_ack     = 1'b0;
      if (r_state == S_HANG) begin
         // fetch is bubbling, so exc/eret go out regardless of stall; branches are ignored
         if (w_cls == C_EXC || w_cls == C_ERET) begin
            w_jump  = 1'b1;
            w_jaddr = w_addr;
            w_ack   = 1'b1;
            w_next  = S_IDLE;
         end
      end else if (r_state == S_PEND) begin
         w_stall = bus.stall_req;
         if (w_cls > r_pcls) begin
            w_pcls_n  = w_cls;
            w_paddr_n = w_addr;
         end
         if (!bus.stall_req) begin
            w_jump  = 1'b1;
            w_jaddr = w_paddr_n;
            w_ack   = 1'b1;
            w_next  = S_IDLE;
         end
      end else if (w_cls != C_NONE) begin
         w_stall = bus.stall_req;
         if (bus.stall_req) begin
            w_pcls_n  = w_cls;
            w_paddr_n = w_addr;
            w_next    = S_PEND;
         end else begin
            w_jump  = 1'b1;
            w_jaddr = w_addr;
            w_ack   = 1'b1;
         end
      end else begin
         w_stall = bus.stall_req;
         w_hang  = bus.hang_req;
         if (bus.hang_req && !bus.stall_req) w_next = S_HANG;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pcls  <= C_NONE;
         r_paddr <= '0;
      end else begin
         r_state <= w_next;
         r_pcls  <= w_pcls_n;
         r_paddr <= w_paddr_n;
      end
   end
   assign bus.im_abs_jump         = reset & w_jump;
   assign bus.im_abs_jump_address = reset ? w_jaddr : '0;
   assign bus.im_pc_stall         = reset & w_stall;
   assign bus.im_hang             = reset & w_hang;
   assign bus.redirect_ack        = reset & w_ack;
   assign bus.busy                = r_state != S_IDLE;
`ifdef FETCH_REDIRECT_STATS_EN
   cls_t                  w_iss;
   logic [STAT_WIDTH-1:0] r_exc, r_eret, r_br;
   assign w_iss = (r_state == S_PEND && !(w_cls > r_pcls)) ? r_pcls : w_cls;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_exc  <= '0;
         r_eret <= '0;
         r_br   <= '0;
      end else if (w_ack) begin
         if (w_iss == C_EXC  && ~&r_exc)  r_exc  <= r_exc + 1'b1;
         if (w_iss == C_ERET && ~&r_eret) r_eret <= r_eret + 1'b1;
         if (w_iss == C_BR   && ~&r_br)   r_br   <= r_br + 1'b1;
      end
   end
   assign stat_exc  = r_exc;
   assign stat_eret = r_eret;
   assign stat_br   = r_br;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed plan plus random stimulus against a priority/pending/hang reference model.
module tb_fetch_redirect_ctrl;
   localparam logic [31:0] EXC_VEC = 32'h0000_4180;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   bit m_pend, m_hang;
   int m_pprio;
   logic [31:0] m_paddr;
   always #5 clk = ~clk;
   fetch_redirect_ctrl_if bus();
`ifdef FETCH_REDIRECT_STATS_EN
   localparam int SW = 2;
   logic [SW-1:0] stat_exc, stat_eret, stat_br;
   int cnt[4];
   fetch_redirect_ctrl #(.STAT_WIDTH(SW)) dut (.clk(clk), .reset(reset), .bus(bus),
      .stat_exc(stat_exc), .stat_eret(stat_eret), .stat_br(stat_br));
`else
   fetch_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // compute expected outputs from the current inputs, compare, then advance the model
   task automatic step();
      int rp, ip;
      logic [31:0] ra, ea;
      bit ej, es, eh, eb;
      rp = bus.exc_req ? 3 : bus.eret_req ? 2 : bus.br_req ? 1 : 0;
      ra = bus.exc_req ? EXC_VEC : bus.eret_req ? bus.epc : bus.br_target;
      ej = 0; es = 0; eh = 0; ea = 0; ip = 0;
      eb = m_pend || m_hang;
      if (!reset) begin
         m_pend = 0; m_hang = 0; m_pprio = 0; m_paddr = 0; eb = 0;
`ifdef FETCH_REDIRECT_STATS_EN
         cnt = '{0, 0, 0, 0};
`endif
      end else if (m_hang) begin
         if (rp >= 2) begin ej = 1; ea = ra; ip = rp; m_hang = 0; end
      end else if (m_pend) begin
         es = bus.stall_req;
         if (rp > m_pprio) begin m_pprio = rp; m_paddr = ra; end
         if (!bus.stall_req) begin ej = 1; ea = m_paddr; ip = m_pprio; m_pend = 0; end
      end else if (rp > 0) begin
         es = bus.stall_req;
         if (bus.stall_req) begin m_pend = 1; m_pprio = rp; m_paddr = ra; end
         else begin ej = 1; ea = ra; ip = rp; end
      end else begin
         es = bus.stall_req;
         eh = bus.hang_req;
         if (bus.hang_req && !bus.stall_req) m_hang = 1;
      end
      chk("jump", {31'b0, bus.im_abs_jump}, {31'b0, ej});
      chk("ack", {31'b0, bus.redirect_ack}, {31'b0, ej});
      chk("pc_stall", {31'b0, bus.im_pc_stall}, {31'b0, es});
      chk("hang", {31'b0, bus.im_hang}, {31'b0, eh});
      chk("busy", {31'b0, bus.busy}, {31'b0, eb});
      if (ej || !reset) chk("addr", bus.im_abs_jump_address, ea);
`ifdef FETCH_REDIRECT_STATS_EN
      chk("stat_exc", 32'(stat_exc), 32'(cnt[3]));
      chk("stat_eret", 32'(stat_eret), 32'(cnt[2]));
      chk("stat_br", 32'(stat_br), 32'(cnt[1]));
      if (ej && cnt[ip] < 3) cnt[ip]++;
`else
      if (ip < 0) $display("unreachable");
`endif
   endtask

   task automatic cyc(input bit rs, input bit st, input bit ex, input bit er, input bit br,
                      input bit hg, input logic [31:0] ep, input logic [31:0] bt);
      @(negedge clk);
      reset = rs; bus.stall_req = st; bus.exc_req = ex; bus.eret_req = er;
      bus.br_req = br; bus.hang_req = hg; bus.epc = ep; bus.br_target = bt;
      #2 step();
   endtask

   initial begin
      bus.stall_req = 0; bus.exc_req = 0; bus.eret_req = 0; bus.br_req = 0;
      bus.hang_req = 0; bus.epc = 0; bus.br_target = 0;
      m_pend = 0; m_hang = 0; m_pprio = 0; m_paddr = 0;
      cyc(0, 1, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 32'h3040);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3080);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3080);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3080);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3080);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3200);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 32'h3100);
      cyc(1, 1, 0, 1, 0, 0, 32'h3024, 0);
      cyc(1, 1, 0, 0, 1, 0, 0, 32'h3010);
      cyc(1, 1, 0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0, 0, 32'h3300 + 32'(i * 4));
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(99) != 0, $urandom_range(9) < 4, $urandom_range(9) == 0,
             $urandom_range(9) == 0, $urandom_range(3) == 0, $urandom_range(6) == 0,
             $urandom, $urandom);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences all control-flow redirects into the instruction-fetch unit.
- Arbitrates exception, ERET and branch/jump redirect requests and drives the fetch unit's absolute-jump, stall and hang inputs.
- Holds a redirect that arrives while fetch is stalled, and issues it on the first unstalled cycle.
- Manages the hang/bubble window after a trapping instruction until a release redirect arrives.

Parameters:
- EXC_VECTOR, 32'h0000_4180, byte address issued for any exception redirect.
- STAT_WIDTH, 16, width of each redirect counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- stall_req  input  1  pipeline hazard stall request for fetch.
- exc_req  input  1  exception/interrupt redirect request.
- eret_req  input  1  ERET redirect request.
- epc  input  32  ERET target byte address; valid with eret_req.
- br_req  input  1  branch/jump redirect request.
- br_target  input  32  branch target byte address; valid with br_req.
- hang_req  input  1  trapping instruction in decode; fetch must hang.
- im_abs_jump  output  1  to fetch unit absolute-jump input.
- im_abs_jump_address  output  32  to fetch unit jump address input.
- im_pc_stall  output  1  to fetch unit PC stall input.
- im_hang  output  1  to fetch unit hang input.
- redirect_ack  output  1  pulse: the redirect presented this cycle was consumed by fetch.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, PENDING, HANG. Reset (reset low, async) forces IDLE, clears the pending register to address 0, and clears all counters. While reset is low, all outputs are 0.
- Priority each cycle: exc_req > eret_req > br_req. Winner address: EXC_VECTOR, epc or br_target respectively. Losing requests that cycle are dropped; the requester re-asserts if needed.
- Addresses are forwarded unmodified. No alignment check is done here; the fetch unit flags misaligned PCs.
- IDLE, no request: im_pc_stall = stall_req; im_hang = hang_req; im_abs_jump = 0.
- IDLE, request, stall_req = 0:
  - im_abs_jump = 1 and im_abs_jump_address = winner, combinationally, in the same cycle (zero latency).
  - im_pc_stall = 0; redirect_ack = 1; stay IDLE.
  - hang_req is masked (im_hang = 0), because the redirect wins.
- IDLE, request, stall_req = 1:
  - im_abs_jump = 0; latch winner address and source class into the pending register; next state PENDING.
  - redirect_ack = 0.
- PENDING:
  - im_pc_stall = stall_req.
  - A new request replaces the pending entry only if its class has strictly higher priority, i.e. exc over eret/br and eret over br. Equal or lower priority is ignored.
  - When stall_req = 0: im_abs_jump = 1 with the pending address (or the replacing higher-priority address, same cycle), redirect_ack = 1, next state IDLE.
- Hang entry: IDLE, hang_req = 1, stall_req = 0, no redirect request -> im_hang = 1 for one cycle, next state HANG. hang_req while stall_req = 1 is not captured; the requester holds it.
- HANG:
  - im_hang = 0 and im_pc_stall = 0; the fetch unit holds its own hang state.
  - br_req is ignored.
  - exc_req or eret_req issues im_abs_jump immediately, with redirect_ack = 1, next state IDLE, regardless of stall_req, because fetch is bubbling.
- busy = (state != IDLE).
- redirect_ack is combinational and is never asserted while reset is low.

Optional Feature:
- Macro: FETCH_REDIRECT_STATS_EN.
- Defined:
  - Adds three STAT_WIDTH outputs: stat_exc, stat_eret, stat_br.
  - Each counter increments on every redirect_ack of its class and saturates at all-ones (no wrap).
  - Counters are cleared only by reset.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset low mid-PENDING with pending addr 0x3010 -> outputs 0, state IDLE; after release, stall_req = 0 with no request gives im_abs_jump = 0 (pending discarded).
- IDLE: br_req = 1, br_target = 0x3040, stall_req = 0 -> same cycle: im_abs_jump = 1, address 0x3040, redirect_ack = 1, busy stays 0.
- br_req (target 0x3080) with stall_req = 1 for 3 cycles -> im_abs_jump = 0 for 3 cycles, busy = 1; cycle 4 (stall_req = 0): im_abs_jump = 1, address 0x3080, ack = 1, then IDLE.
- PENDING with br target 0x3080; exc_req pulses during the stall -> on release, address 0x4180; a later br_req during PENDING does not replace it.
- hang_req = 1 in IDLE -> im_hang = 1 for one cycle, state HANG; br_req 0x3100 is ignored; eret_req with epc = 0x3024 -> im_abs_jump = 1, address 0x3024, state IDLE.
- With FETCH_REDIRECT_STATS_EN and STAT_WIDTH = 2: 5 branch redirects -> stat_br = 3 (saturated); 1 exception -> stat_exc = 1.
